// File: rtl/serial_word_pkg.sv
// Shared types for the serial word receiver.
// Receiver state encoding and the default word width.
package serial_word_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } rx_state_t;

endpackage

// File: rtl/word_out_reg.sv
// One-entry valid/ready holding register for assembled words.
// Ports: load/word_in fill it; m_valid/m_data/m_ready drain it; full = cannot accept.
module word_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word_in,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             full
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= word_in;
    end else if (valid_q && m_ready) begin
      valid_q <= 1'b0;
    end
  end

  // A word leaving this cycle frees the slot for one arriving now.
  assign full    = valid_q && !m_ready;
  assign m_valid = valid_q;
  assign m_data  = data_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Framed LSB-first serial-to-parallel receiver with a one-word output register.
// Ports: s_valid/s_bit/s_frame in; m_data/m_valid/m_ready out; busy, overflow, frame_err, clr_err.
module serial_word_receiver
  import serial_word_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             s_frame,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             overflow,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             load, full;
  logic             ovf_set, ferr_set;

  // New bit enters at the top; after WIDTH bits, bit 0 sits at the bottom.
  assign shifted = (shreg_q >> 1)
                 | (WIDTH'(s_bit) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    load     = 1'b0;
    ovf_set  = 1'b0;
    ferr_set = 1'b0;
    if (s_valid) begin
      unique case (state_q)
        IDLE: begin
          if (s_frame) begin
            shreg_d = shifted;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shreg_d = shifted;
          if (s_frame) begin
            ferr_set = 1'b1;
            cnt_d    = CW'(1);
          end else if (cnt_q == LAST) begin
            load    = !full;
            ovf_set = full;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Set wins over a simultaneous clear.
    ovf_d  = ovf_set  | (ovf_q  & ~clr_err);
    ferr_d = ferr_set | (ferr_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  word_out_reg #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .word_in(shifted),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .full   (full)
  );

  assign busy      = (state_q == SHIFT);
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-in, parallel-out receiver for the LSB-first bit stream produced by the team's 8-bit right-rotating parallel-load shift register, which exposes bit 0 first.
- Collects framed serial bits, reassembles each word in its original bit order, and presents it on a one-entry valid/ready output register.
- Sits on the receive side of the serial link and feeds word-level consumers.
- Reports dropped words and broken frames through sticky flags.

## Interface
- WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  bit strobe; s_bit and s_frame are sampled only when s_valid=1.
- s_bit  input  1  serial data bit, LSB first.
- s_frame  input  1  marks the first bit (bit 0) of a word.
- m_data  output  WIDTH  assembled word.
- m_valid  output  1  m_data holds an unconsumed word.
- m_ready  input  1  consumer accepts m_data when m_valid && m_ready.
- busy  output  1  a word is partially received (state SHIFT).
- overflow  output  1  sticky; a completed word was dropped because the output register was full.
- frame_err  output  1  sticky; a partial word was abandoned because of a new s_frame.
- clr_err  input  1  synchronous clear of overflow and frame_err.

## Operation
- Reset values: m_data=0, m_valid=0, busy=0, overflow=0, frame_err=0, state=IDLE, bit count=0, shift register=0.
- Assembly is a right shift: shreg <= {s_bit, shreg[WIDTH-1:1]}. After WIDTH bits, shreg equals the transmitted word.
- Bit count cnt is $clog2(WIDTH) bits wide and counts the bits received in the current word.
- IDLE state:
  - s_valid && s_frame: capture the bit, set cnt=1, go to SHIFT.
  - s_valid && !s_frame: ignore the bit (unframed noise).
- SHIFT state, on s_valid && s_frame: set frame_err, discard the partial word, capture the bit as the new bit 0, set cnt=1, stay in SHIFT.
- SHIFT state, on s_valid && !s_frame && cnt < WIDTH-1: shift the bit in, cnt++.
- SHIFT state, on s_valid && !s_frame && cnt == WIDTH-1 (word complete):
  - The assembled word is {s_bit, shreg[WIDTH-1:1]}.
  - If the output register is free, load the word and set m_valid. Free means !m_valid, or m_valid && m_ready in the same cycle.
  - Otherwise set overflow, drop the new word, and leave m_data/m_valid unchanged.
  - In both cases go to IDLE with cnt=0.
- Output handshake:
  - m_valid && m_ready with no new word loading: clear m_valid. m_data holds its last value.
  - m_data must not change while m_valid && !m_ready.
- Sticky flags:
  - clr_err clears overflow and frame_err.
  - If a set condition and clr_err occur in the same cycle, the flag ends set.
- Mid-operation reset: asynchronously discards the partial word, the output word and the flags. No word is emitted after rst_n deasserts until a new framed word completes.

## Timing
- Latency: m_valid rises on the clock edge that samples the WIDTH-th bit, so it is visible in the following cycle.
- Full-rate strobes (s_valid=1 every cycle) sustain one word every WIDTH cycles with no bubble, provided the consumer drains within WIDTH cycles.
- Gaps in s_valid stall assembly indefinitely. There is no timeout.
- busy follows the state: 1 in SHIFT, 0 in IDLE. It reads 0 in the cycle after word completion.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package serial_word_pkg holds:
  - state typedef rx_state_t {IDLE, SHIFT};
  - localparam DEFAULT_WIDTH=8.
- Single module. The output holding register plus its handshake is a natural sub-module, word_out_reg, with parameter WIDTH and ports load/word_in/m_ready/m_valid/m_data/full.

## Test plan
- 0xA5 sent as bits 1,0,1,0,0,1,0,1 (frame on the first bit), s_valid every cycle, m_ready=1 -> m_data=0xA5 with m_valid for exactly one cycle, one cycle after the 8th strobe; busy high for 7 cycles.
- 0x3C with random 0-3 cycle gaps in s_valid -> m_data=0x3C; unframed bits sent in IDLE before the frame are ignored.
- m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11, overflow=1; then m_ready=1 -> 0x11 consumed; clr_err -> overflow=0.
- Send 5 bits of 0xFF, then restart with s_frame carrying 0x96 -> frame_err=1, single output 0x96.
- m_valid=1 holding 0x01, m_ready pulses in the same cycle 0x80 completes -> 0x01 consumed, m_data=0x80, m_valid stays 1, overflow=0.
- Assert rst_n=0 after 4 bits of 0xC3 -> all outputs 0 immediately; then a full 0x5A is received correctly.
